// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants and state encodings for the memory arbiter
package mem_arb_pkg;

    localparam int ADDR_W_DEFAULT = 13;
    localparam int MEM_DATA_W     = 32;
    localparam int WB_DATA_W      = 8;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_RD_I = 2'd1;
    localparam arb_state_t ST_RD_D = 2'd2;
    localparam arb_state_t ST_WR   = 2'd3;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - write-through buffer FIFO with count-based full/empty
module wb_fifo #(
    parameter int WB_DEPTH = 4,
    parameter int WIDTH    = 21
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(WB_DEPTH);

    logic [WIDTH-1:0] mem [WB_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == WB_DEPTH[PTR_W:0]);
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];
    assign do_pop    = pop && !empty;
    // A pop in the same cycle frees the head slot, so a push into a full buffer still fits.
    assign do_push   = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for I/D refills and buffered D writes
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int WB_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_rreq,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [MEM_DATA_W-1:0] i_rdata,
    output logic                  i_rvalid,
    input  logic                  d_rreq,
    input  logic [ADDR_W-1:0]     d_raddr,
    output logic [MEM_DATA_W-1:0] d_rdata,
    output logic                  d_rvalid,
    input  logic                  d_wreq,
    input  logic [ADDR_W-1:0]     d_waddr,
    input  logic [WB_DATA_W-1:0]  d_wdata,
    output logic                  wb_full,
    output logic                  wb_empty,
    output logic                  err_overflow,
    output logic                  rreq_to_mem,
    output logic [ADDR_W-1:0]     raddr_to_mem,
    input  logic [MEM_DATA_W-1:0] rdata_from_mem,
    input  logic                  rvalid_from_mem,
    output logic                  wreq_to_mem,
    output logic [ADDR_W-1:0]     waddr_to_mem,
    output logic [WB_DATA_W-1:0]  wdata_to_mem
);

    localparam int WB_W = ADDR_W + WB_DATA_W;

    arb_state_t      state;
    logic            last_grant;
    logic            wb_pop;
    logic [WB_W-1:0] wb_head;
    logic            d_eligible;
    logic            grant_i;
    logic            grant_d;

    assign wb_pop = (state == ST_WR);

    wb_fifo #(
        .WB_DEPTH (WB_DEPTH),
        .WIDTH    (WB_W)
    ) u_wb_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (d_wreq),
        .push_data ({d_waddr, d_wdata}),
        .pop       (wb_pop),
        .head_data (wb_head),
        .full      (wb_full),
        .empty     (wb_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            err_overflow <= 1'b0;
        end else if (d_wreq && wb_full && !wb_pop) begin
            err_overflow <= 1'b1;
        end
    end

    // D-reads only compete once the buffer is empty, so they never bypass a pending write.
    assign d_eligible = d_rreq && wb_empty;

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_rreq && d_eligible) begin
            if (last_grant == GRANT_D) begin
                grant_i = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else if (i_rreq) begin
            grant_i = 1'b1;
        end else if (d_eligible) begin
            grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            last_grant   <= GRANT_D;
            rreq_to_mem  <= 1'b0;
            raddr_to_mem <= '0;
            wreq_to_mem  <= 1'b0;
            waddr_to_mem <= '0;
            wdata_to_mem <= '0;
        end else begin
            wreq_to_mem <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wb_full || (d_rreq && !wb_empty)) begin
                        state <= ST_WR;
                    end else if (grant_i) begin
                        state        <= ST_RD_I;
                        last_grant   <= GRANT_I;
                        rreq_to_mem  <= 1'b1;
                        raddr_to_mem <= i_raddr;
                    end else if (grant_d) begin
                        state        <= ST_RD_D;
                        last_grant   <= GRANT_D;
                        rreq_to_mem  <= 1'b1;
                        raddr_to_mem <= d_raddr;
                    end else if (!wb_empty) begin
                        state <= ST_WR;
                    end
                end
                ST_RD_I, ST_RD_D: begin
                    if (rvalid_from_mem) begin
                        state       <= ST_IDLE;
                        rreq_to_mem <= 1'b0;
                    end
                end
                ST_WR: begin
                    wreq_to_mem                  <= 1'b1;
                    {waddr_to_mem, wdata_to_mem} <= wb_head;
                    state                        <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_rvalid = (state == ST_RD_I) && rvalid_from_mem;
    assign d_rvalid = (state == ST_RD_D) && rvalid_from_mem;
    assign i_rdata  = i_rvalid ? rdata_from_mem : '0;
    assign d_rdata  = d_rvalid ? rdata_from_mem : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int AW    = 13;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_rreq, d_rreq, d_wreq, rvalid_from_mem;
    logic [AW-1:0] i_raddr, d_raddr, d_waddr;
    logic [7:0]    d_wdata;
    logic [31:0]   rdata_from_mem, i_rdata, d_rdata;
    logic          i_rvalid, d_rvalid, wb_full, wb_empty, err_overflow;
    logic          rreq_to_mem, wreq_to_mem;
    logic [AW-1:0] raddr_to_mem, waddr_to_mem;
    logic [7:0]    wdata_to_mem;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_W(AW), .WB_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .i_rreq          (i_rreq),
        .i_raddr         (i_raddr),
        .i_rdata         (i_rdata),
        .i_rvalid        (i_rvalid),
        .d_rreq          (d_rreq),
        .d_raddr         (d_raddr),
        .d_rdata         (d_rdata),
        .d_rvalid        (d_rvalid),
        .d_wreq          (d_wreq),
        .d_waddr         (d_waddr),
        .d_wdata         (d_wdata),
        .wb_full         (wb_full),
        .wb_empty        (wb_empty),
        .err_overflow    (err_overflow),
        .rreq_to_mem     (rreq_to_mem),
        .raddr_to_mem    (raddr_to_mem),
        .rdata_from_mem  (rdata_from_mem),
        .rvalid_from_mem (rvalid_from_mem),
        .wreq_to_mem     (wreq_to_mem),
        .waddr_to_mem    (waddr_to_mem),
        .wdata_to_mem    (wdata_to_mem)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rreq = 0; d_rreq = 0; d_wreq = 0; rvalid_from_mem = 0;
        i_raddr = '0; d_raddr = '0; d_waddr = '0; d_wdata = '0; rdata_from_mem = '0;
        reset = 1;
        cyc();
        cyc();
        reset = 0;
        cyc();
    endtask

    task automatic wait_rreq(output bit ok);
        ok = 0;
        for (int n = 0; n < 40; n++) begin
            if (rreq_to_mem) begin
                ok = 1;
                break;
            end
            cyc();
        end
    endtask

    task automatic write_pulse(input logic [AW-1:0] a, input logic [7:0] d);
        d_waddr = a;
        d_wdata = d;
        d_wreq  = 1;
        cyc();
        d_wreq  = 0;
    endtask

    task automatic serve(input int lat, input logic [31:0] data, output bit ok,
                         output logic [AW-1:0] addr, output logic iv, output logic dv,
                         output logic [31:0] ird, output logic [31:0] drd);
        wait_rreq(ok);
        addr = raddr_to_mem;
        repeat (lat) cyc();
        rdata_from_mem  = data;
        rvalid_from_mem = ok;
        @(negedge clk);
        iv  = i_rvalid;
        dv  = d_rvalid;
        ird = i_rdata;
        drd = d_rdata;
        cyc();
        rvalid_from_mem = 0;
        rdata_from_mem  = '0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (wb_empty !== 1'b1) begin
            bad++; $display("FAIL reset_wb_empty got=%b want=1", wb_empty);
        end
        total++;
        if ({wb_full, err_overflow, rreq_to_mem, wreq_to_mem, i_rvalid, d_rvalid} !== 6'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=000000",
                {wb_full, err_overflow, rreq_to_mem, wreq_to_mem, i_rvalid, d_rvalid});
        end
        total++;
        if ({raddr_to_mem, waddr_to_mem, wdata_to_mem, i_rdata, d_rdata} !== '0) begin
            bad++; $display("FAIL reset_buses got=%h want=0",
                {raddr_to_mem, waddr_to_mem, wdata_to_mem, i_rdata, d_rdata});
        end
    endtask

    task automatic test_i_read();
        bit ok;
        i_raddr = 13'h0040;
        i_rreq  = 1;
        cyc();
        wait_rreq(ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL iread_grant got=%b want=1", ok); end
        total++;
        if (raddr_to_mem !== 13'h0040) begin
            bad++; $display("FAIL iread_addr got=%h want=0040", raddr_to_mem);
        end
        repeat (3) cyc();
        total++;
        if (rreq_to_mem !== 1'b1) begin bad++; $display("FAIL iread_hold got=%b want=1", rreq_to_mem); end
        rdata_from_mem  = 32'hDEADBEEF;
        rvalid_from_mem = 1;
        @(negedge clk);
        total++;
        if ({i_rvalid, d_rvalid} !== 2'b10 || i_rdata !== 32'hDEADBEEF || d_rdata !== 32'h0) begin
            bad++; $display("FAIL iread_resp got=%b/%h/%h want=10/deadbeef/0",
                {i_rvalid, d_rvalid}, i_rdata, d_rdata);
        end
        cyc();
        rvalid_from_mem = 0;
        i_rreq = 0;
        total++;
        if (rreq_to_mem !== 1'b0) begin bad++; $display("FAIL iread_release got=%b want=0", rreq_to_mem); end
        cyc();
    endtask

    task automatic test_tie();
        bit ok;
        logic [AW-1:0] ia, da, addr;
        logic iv, dv;
        logic [31:0] ird, drd, dat1, dat2;
        do_reset();
        ia = AW'($urandom); da = AW'($urandom);
        dat1 = $urandom; dat2 = $urandom;
        i_raddr = ia; d_raddr = da;
        i_rreq = 1; d_rreq = 1;
        serve($urandom_range(0, 3), dat1, ok, addr, iv, dv, ird, drd);
        i_rreq = 0;
        total++;
        if (!ok || addr !== ia || {iv, dv} !== 2'b10 || ird !== dat1) begin
            bad++; $display("FAIL tie_first got=%h/%b/%h want=%h/10/%h", addr, {iv, dv}, ird, ia, dat1);
        end
        serve($urandom_range(0, 3), dat2, ok, addr, iv, dv, ird, drd);
        d_rreq = 0;
        total++;
        if (!ok || addr !== da || {iv, dv} !== 2'b01 || drd !== dat2) begin
            bad++; $display("FAIL tie_second got=%h/%b/%h want=%h/01/%h", addr, {iv, dv}, drd, da, dat2);
        end
    endtask

    task automatic test_raw();
        logic [AW+7:0] exp_q[$];
        logic [AW+7:0] got_q[$];
        logic [31:0] dat;
        bit got_rreq;
        do_reset();
        exp_q.push_back({13'h0100, 8'h11});
        exp_q.push_back({13'h0101, 8'h22});
        write_pulse(13'h0100, 8'h11);
        write_pulse(13'h0101, 8'h22);
        d_raddr = 13'h0100;
        d_rreq  = 1;
        got_rreq = 0;
        for (int n = 0; n < 40 && !got_rreq; n++) begin
            cyc();
            if (wreq_to_mem) got_q.push_back({waddr_to_mem, wdata_to_mem});
            if (rreq_to_mem) got_rreq = 1;
        end
        total++;
        if (!got_rreq || got_q.size() != 2) begin
            bad++; $display("FAIL raw_order rreq=%b writes_before=%0d want 1/2", got_rreq, got_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL raw_write%0d got=%h want=%h", i,
                    (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            end
        end
        total++;
        if (raddr_to_mem !== 13'h0100) begin bad++; $display("FAIL raw_raddr got=%h want=0100", raddr_to_mem); end
        dat = $urandom;
        rdata_from_mem  = dat;
        rvalid_from_mem = 1;
        @(negedge clk);
        total++;
        if ({i_rvalid, d_rvalid} !== 2'b01 || d_rdata !== dat) begin
            bad++; $display("FAIL raw_resp got=%b/%h want=01/%h", {i_rvalid, d_rvalid}, d_rdata, dat);
        end
        cyc();
        rvalid_from_mem = 0;
        d_rreq = 0;
    endtask

    task automatic test_overflow();
        bit ok;
        logic [AW+7:0] exp_q[$];
        logic [AW+7:0] got_q[$];
        logic [AW-1:0] a;
        logic [7:0] d;
        do_reset();
        i_raddr = AW'($urandom);
        i_rreq  = 1;
        cyc();
        wait_rreq(ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL ovf_grant got=%b want=1", ok); end
        for (int k = 0; k < 5; k++) begin
            a = AW'($urandom); d = 8'($urandom);
            if (k < DEPTH) exp_q.push_back({a, d});
            write_pulse(a, d);
        end
        total++;
        if ({wb_full, wb_empty, err_overflow} !== 3'b101) begin
            bad++; $display("FAIL ovf_flags full/empty/err got=%b want=101", {wb_full, wb_empty, err_overflow});
        end
        rvalid_from_mem = 1;
        rdata_from_mem  = $urandom;
        @(negedge clk);
        total++;
        if (i_rvalid !== 1'b1) begin bad++; $display("FAIL ovf_iresp got=%b want=1", i_rvalid); end
        cyc();
        rvalid_from_mem = 0;
        i_rreq = 0;
        for (int n = 0; n < 30; n++) begin
            cyc();
            if (wreq_to_mem) got_q.push_back({waddr_to_mem, wdata_to_mem});
        end
        total++;
        if (got_q.size() != DEPTH) begin bad++; $display("FAIL ovf_count got=%0d want=%0d", got_q.size(), DEPTH); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL ovf_write%0d got=%h want=%h", i,
                    (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            end
        end
        total++;
        if ({wb_empty, err_overflow} !== 2'b11) begin
            bad++; $display("FAIL ovf_after empty/err got=%b want=11", {wb_empty, err_overflow});
        end
    endtask

    task automatic test_drain();
        bit ok;
        logic [AW+7:0] exp_q[$];
        logic [AW+7:0] got_q[$];
        logic [AW-1:0] a;
        logic [7:0] d;
        logic [31:0] dat;
        int first_evt, lat, reads_done;
        do_reset();
        i_raddr = AW'($urandom);
        i_rreq  = 1;
        cyc();
        wait_rreq(ok);
        for (int k = 0; k < DEPTH; k++) begin
            a = AW'($urandom); d = 8'($urandom);
            exp_q.push_back({a, d});
            write_pulse(a, d);
        end
        total++;
        if (wb_full !== 1'b1) begin bad++; $display("FAIL drain_full got=%b want=1", wb_full); end
        rvalid_from_mem = 1;
        rdata_from_mem  = $urandom;
        cyc();
        rvalid_from_mem = 0;
        first_evt = 0;
        reads_done = 0;
        lat = $urandom_range(0, 2);
        for (int n = 0; n < 200 && got_q.size() < DEPTH; n++) begin
            cyc();
            rvalid_from_mem = 0;
            if (reads_done >= 2) i_rreq = 0;
            if (wreq_to_mem) begin
                got_q.push_back({waddr_to_mem, wdata_to_mem});
                if (first_evt == 0) first_evt = 1;
            end
            if (rreq_to_mem) begin
                if (first_evt == 0) first_evt = 2;
                if (lat == 0) begin
                    dat = $urandom;
                    rdata_from_mem  = dat;
                    rvalid_from_mem = 1;
                    lat = $urandom_range(0, 2);
                    reads_done++;
                    @(negedge clk);
                    total++;
                    if (i_rvalid !== 1'b1 || i_rdata !== dat) begin
                        bad++; $display("FAIL drain_iresp got=%b/%h want=1/%h", i_rvalid, i_rdata, dat);
                    end
                end else begin
                    lat--;
                end
            end
        end
        i_rreq = 0;
        total++;
        if (first_evt != 1) begin bad++; $display("FAIL drain_first_event got=%0d want=1 (write)", first_evt); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL drain_write%0d got=%h want=%h", i,
                    (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        logic [31:0] dat;
        do_reset();
        d_raddr = AW'($urandom);
        d_rreq  = 1;
        cyc();
        wait_rreq(ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL rstmid_grant got=%b want=1", ok); end
        cyc();
        reset  = 1;
        d_rreq = 0;
        cyc();
        reset = 0;
        dat = $urandom;
        rdata_from_mem  = dat;
        rvalid_from_mem = 1;
        @(negedge clk);
        total++;
        if ({i_rvalid, d_rvalid} !== 2'b00 || d_rdata !== 32'h0 || i_rdata !== 32'h0) begin
            bad++; $display("FAIL rstmid_stray got=%b/%h want=00/0", {i_rvalid, d_rvalid}, d_rdata);
        end
        cyc();
        rvalid_from_mem = 0;
        seen = 0;
        for (int n = 0; n < 4; n++) begin
            seen |= rreq_to_mem | wreq_to_mem;
            cyc();
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b want=0", seen); end
        total++;
        if ({wb_empty, wb_full, err_overflow, raddr_to_mem} !== {1'b1, 2'b00, {AW{1'b0}}}) begin
            bad++; $display("FAIL rstmid_outputs got=%b/%h want=100/0",
                {wb_empty, wb_full, err_overflow}, raddr_to_mem);
        end
    endtask

    task automatic test_random();
        logic [AW+7:0] wexp[$];
        logic [AW+7:0] w_head;
        logic [AW-1:0] a;
        logic [7:0] d;
        logic [31:0] rd;
        logic i_pend, d_pend, rd_active, resp, stray, exp_d;
        int lat;
        do_reset();
        i_pend = 0; d_pend = 0; rd_active = 0; exp_d = 0; rd = '0;
        lat = $urandom_range(0, 3);
        for (int n = 0; n < 600; n++) begin
            cyc();
            if (wreq_to_mem) begin
                total++;
                if (wexp.size() == 0 || {waddr_to_mem, wdata_to_mem} !== wexp[0]) begin
                    bad++; $display("FAIL rand_write got=%h want=%h", {waddr_to_mem, wdata_to_mem},
                        (wexp.size() != 0) ? wexp[0] : '0);
                end
                if (wexp.size() != 0) w_head = wexp.pop_front();
            end
            if (rreq_to_mem && !rd_active) begin
                rd_active = 1;
                total++;
                if (raddr_to_mem[0]) begin
                    // only a write pushed on the decision edge itself may still be outstanding
                    if (!d_pend || raddr_to_mem !== d_raddr || (wexp.size() - int'(d_wreq)) != 0) begin
                        bad++; $display("FAIL rand_dread addr=%h want=%h pend=%b writes_ahead=%0d",
                            raddr_to_mem, d_raddr, d_pend, wexp.size() - int'(d_wreq));
                    end
                end else begin
                    if (!i_pend || raddr_to_mem !== i_raddr) begin
                        bad++; $display("FAIL rand_iread addr=%h want=%h pend=%b", raddr_to_mem, i_raddr, i_pend);
                    end
                end
            end
            rvalid_from_mem = 0;
            resp = 0;
            stray = 0;
            if (rreq_to_mem) begin
                if (lat == 0) begin
                    resp = 1;
                    exp_d = raddr_to_mem[0];
                    lat = $urandom_range(0, 3);
                    rd_active = 0;
                end else begin
                    lat--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                stray = 1;
            end
            if (resp || stray) begin
                rd = $urandom;
                rdata_from_mem  = rd;
                rvalid_from_mem = 1;
            end
            d_wreq = 0;
            if (n < 500 && wexp.size() < 3 && $urandom_range(0, 3) == 0) begin
                a = AW'($urandom); d = 8'($urandom);
                d_waddr = a; d_wdata = d; d_wreq = 1;
                wexp.push_back({a, d});
            end
            if (n < 500 && !i_pend && !i_rreq && $urandom_range(0, 3) == 0) begin
                a = AW'($urandom); a[0] = 1'b0;
                i_raddr = a; i_rreq = 1; i_pend = 1;
            end
            if (!i_pend) i_rreq = 0;
            if (n < 500 && !d_pend && !d_rreq && $urandom_range(0, 3) == 0) begin
                a = AW'($urandom); a[0] = 1'b1;
                d_raddr = a; d_rreq = 1; d_pend = 1;
            end
            if (!d_pend) d_rreq = 0;
            @(negedge clk);
            total++;
            if (resp && exp_d) begin
                if ({i_rvalid, d_rvalid} !== 2'b01 || d_rdata !== rd || i_rdata !== 32'h0 || !d_pend) begin
                    bad++; $display("FAIL rand_dresp got=%b/%h want=01/%h pend=%b", {i_rvalid, d_rvalid}, d_rdata, rd, d_pend);
                end
                d_pend = 0;
            end else if (resp) begin
                if ({i_rvalid, d_rvalid} !== 2'b10 || i_rdata !== rd || d_rdata !== 32'h0 || !i_pend) begin
                    bad++; $display("FAIL rand_iresp got=%b/%h want=10/%h pend=%b", {i_rvalid, d_rvalid}, i_rdata, rd, i_pend);
                end
                i_pend = 0;
            end else begin
                if ({i_rvalid, d_rvalid} !== 2'b00) begin
                    bad++; $display("FAIL rand_quiet got=%b want=00 stray=%b", {i_rvalid, d_rvalid}, stray);
                end
            end
        end
        d_wreq = 0;
        rvalid_from_mem = 0;
        total++;
        if (wexp.size() != 0 || i_pend || d_pend || err_overflow !== 1'b0) begin
            bad++; $display("FAIL rand_end writes_left=%0d ipend=%b dpend=%b err=%b want 0/0/0/0",
                wexp.size(), i_pend, d_pend, err_overflow);
        end
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_tie();
        test_raw();
        test_overflow();
        test_drain();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
